mmio_uart_bridge: RTL and testbench

- Parametrised memory-mapped I/O bridge; it is the next generation of the UART/LED MMIO logic in the pipelined core.
- It sits at the MEM stage beside the data BRAM and decodes the EX/MEM address, write data and strobes.
- It adds buffered TX and RX FIFOs, sticky error flags, FIFO level readback, interrupt enables and an autonomous TX drain FSM.
- Existing software that polls STATUS bit0/bit1 and uses DATA at UART_BASE keeps working unchanged.

---
 rtl/mmio_uart_bridge_pkg.sv | 29 ++
 rtl/mmio_uart_bridge_sync_fifo.sv | 57 +++++
 rtl/mmio_uart_bridge.sv | 193 +++++++++++++++++++
 tb/tb_mmio_uart_bridge.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_bridge_pkg.sv
// Shared definitions for the MMIO UART/LED bridge: register word indices,
// STATUS/CTRL bit positions and the TX drain state encoding.
package mmio_uart_bridge_pkg;

    // Word index within the UART block, taken from bus_addr[3:2]
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_LEVEL  = 2'd3;

    localparam int ST_RX_NONEMPTY = 0;
    localparam int ST_TX_BUSY     = 1;
    localparam int ST_TX_FULL     = 2;
    localparam int ST_RX_FULL     = 3;
    localparam int ST_RX_OVERRUN  = 4;
    localparam int ST_TX_DROP     = 5;

    localparam int CTRL_RX_IRQ_EN   = 0;
    localparam int CTRL_TX_IRQ_EN   = 1;
    localparam int CTRL_CLR_OVERRUN = 4;
    localparam int CTRL_CLR_DROP    = 5;

    typedef enum logic [1:0] {
        TX_IDLE   = 2'd0,
        TX_LAUNCH = 2'd1,
        TX_HOLD   = 2'd2
    } tx_state_t;

endpackage

// File: rtl/mmio_uart_bridge_sync_fifo.sv
// Single-clock FIFO with head-of-queue visible combinationally; full/empty
// reflect the registered count, so same-cycle push/pop never see each other.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr_reg];
    assign count   = count_reg;

    // Storage carries no reset so it maps onto plain RAM
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_bridge.sv
// MEM-stage MMIO bridge: buffered UART TX/RX with status, control, level
// readback and interrupts, plus an LED register.
module mmio_uart_bridge
    import mmio_uart_bridge_pkg::*;
#(
    parameter int          TX_DEPTH  = 16,
    parameter int          RX_DEPTH  = 16,
    parameter int          LED_WIDTH = 16,
    parameter logic [31:0] UART_BASE = 32'h1000_0000,
    parameter logic [31:0] LED_BASE  = 32'h2000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          bus_addr,
    input  logic [31:0]          bus_wdata,
    input  logic                 bus_we,
    input  logic                 bus_re,
    output logic [31:0]          bus_rdata,
    output logic                 bus_hit,
    output logic [7:0]           uart_tx_data_out,
    output logic                 uart_tx_we_out,
    input  logic                 uart_tx_busy_in,
    input  logic [7:0]           uart_rx_data_in,
    input  logic                 uart_rx_valid_in,
    output logic                 uart_rx_re_out,
    output logic [LED_WIDTH-1:0] led_out,
    output logic                 irq_out
);
    localparam int TCW = $clog2(TX_DEPTH) + 1;
    localparam int RCW = $clog2(RX_DEPTH) + 1;

    logic       uart_sel;
    logic       led_sel;
    logic [1:0] reg_idx;

    assign uart_sel = (bus_addr[31:4] == UART_BASE[31:4]);
    assign led_sel  = (bus_addr[31:2] == LED_BASE[31:2]);
    assign reg_idx  = bus_addr[3:2];
    assign bus_hit  = uart_sel | led_sel;

    logic unused_bits;
    assign unused_bits = &{1'b0, bus_addr[1:0], bus_wdata};

    logic           tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]     tx_head;
    logic [TCW-1:0] tx_count;
    logic           rx_pop, rx_full, rx_empty;
    logic [7:0]     rx_head;
    logic [RCW-1:0] rx_count;

    logic           rx_ack_reg;
    logic [7:0]     rx_byte_reg;
    logic           rx_irq_en_reg, tx_irq_en_reg;
    logic           rx_overrun_reg, tx_drop_reg;
    logic [LED_WIDTH-1:0] led_reg;
    logic           ctrl_wr;

    assign tx_push = bus_we & uart_sel & (reg_idx == REG_DATA);
    assign rx_pop  = bus_re & uart_sel & (reg_idx == REG_DATA);
    assign ctrl_wr = bus_we & uart_sel & (reg_idx == REG_CTRL);

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .wdata (bus_wdata[7:0]),
        .pop   (tx_pop),
        .head  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_ack_reg),
        .wdata (rx_byte_reg),
        .pop   (rx_pop),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // TX drain FSM
    tx_state_t  state_reg, state_next;
    logic       hold_done_reg, hold_done_next;
    logic [7:0] tx_data_reg, tx_data_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= TX_IDLE;
            hold_done_reg <= 1'b0;
            tx_data_reg   <= 8'h00;
        end else begin
            state_reg     <= state_next;
            hold_done_reg <= hold_done_next;
            tx_data_reg   <= tx_data_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        hold_done_next = hold_done_reg;
        tx_data_next   = tx_data_reg;
        case (state_reg)
            TX_IDLE: begin
                // Head is captured here so it is stable for the whole launch cycle
                if (!tx_empty && !uart_tx_busy_in) begin
                    state_next   = TX_LAUNCH;
                    tx_data_next = tx_head;
                end
            end
            TX_LAUNCH: begin
                state_next     = TX_HOLD;
                hold_done_next = 1'b0;
            end
            TX_HOLD: begin
                hold_done_next = 1'b1;
                if (hold_done_reg && !uart_tx_busy_in) state_next = TX_IDLE;
            end
            default: state_next = TX_IDLE;
        endcase
    end

    // Decoded from the state register so async reset kills the pulse at once
    assign tx_pop           = (state_reg == TX_LAUNCH);
    assign uart_tx_we_out   = tx_pop;
    assign uart_tx_data_out = tx_data_reg;

    // RX capture, control, sticky flags and LED register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_ack_reg     <= 1'b0;
            rx_byte_reg    <= 8'h00;
            rx_irq_en_reg  <= 1'b0;
            tx_irq_en_reg  <= 1'b0;
            rx_overrun_reg <= 1'b0;
            tx_drop_reg    <= 1'b0;
            led_reg        <= '0;
        end else begin
            rx_ack_reg <= uart_rx_valid_in & ~rx_ack_reg;
            if (uart_rx_valid_in && !rx_ack_reg) rx_byte_reg <= uart_rx_data_in;

            if (ctrl_wr) begin
                rx_irq_en_reg <= bus_wdata[CTRL_RX_IRQ_EN];
                tx_irq_en_reg <= bus_wdata[CTRL_TX_IRQ_EN];
            end

            // A new error event wins over a same-cycle clear
            if (rx_ack_reg && rx_full)                   rx_overrun_reg <= 1'b1;
            else if (ctrl_wr && bus_wdata[CTRL_CLR_OVERRUN]) rx_overrun_reg <= 1'b0;

            if (tx_push && tx_full)                      tx_drop_reg <= 1'b1;
            else if (ctrl_wr && bus_wdata[CTRL_CLR_DROP]) tx_drop_reg <= 1'b0;

            if (bus_we && led_sel) led_reg <= bus_wdata[LED_WIDTH-1:0];
        end
    end

    assign uart_rx_re_out = rx_ack_reg;
    assign led_out        = led_reg;
    assign irq_out        = (rx_irq_en_reg & ~rx_empty)
                          | (tx_irq_en_reg & tx_empty & (state_reg == TX_IDLE));

    logic [5:0] status;
    always_comb begin
        status                 = '0;
        status[ST_RX_NONEMPTY] = ~rx_empty;
        status[ST_TX_BUSY]     = ~tx_empty | (state_reg != TX_IDLE) | uart_tx_busy_in;
        status[ST_TX_FULL]     = tx_full;
        status[ST_RX_FULL]     = rx_full;
        status[ST_RX_OVERRUN]  = rx_overrun_reg;
        status[ST_TX_DROP]     = tx_drop_reg;
    end

    always_comb begin
        bus_rdata = 32'h0;
        if (uart_sel) begin
            case (reg_idx)
                REG_DATA:   bus_rdata = rx_empty ? 32'h0 : {24'h0, rx_head};
                REG_STATUS: bus_rdata = {26'h0, status};
                REG_CTRL:   bus_rdata = {30'h0, tx_irq_en_reg, rx_irq_en_reg};
                REG_LEVEL:  bus_rdata = {8'h0, 8'(tx_count), 8'h0, 8'(rx_count)};
                default:    bus_rdata = 32'h0;
            endcase
        end else if (led_sel) begin
            bus_rdata = 32'(led_reg);
        end
    end

endmodule

// File: tb/tb_mmio_uart_bridge.sv
// Directed bench for mmio_uart_bridge (TX_DEPTH=4, RX_DEPTH=16) with a
// simple UART model that stays busy for 10 cycles after each launch.
module tb_mmio_uart_bridge;
    localparam logic [31:0] UB     = 32'h1000_0000;
    localparam logic [31:0] LB     = 32'h2000_0000;
    localparam logic [31:0] A_DATA = UB + 32'h0;
    localparam logic [31:0] A_STAT = UB + 32'h4;
    localparam logic [31:0] A_CTRL = UB + 32'h8;
    localparam logic [31:0] A_LVL  = UB + 32'hC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] bus_addr = 32'h0;
    logic [31:0] bus_wdata = 32'h0;
    logic        bus_we = 1'b0;
    logic        bus_re = 1'b0;
    logic [31:0] bus_rdata;
    logic        bus_hit;
    logic [7:0]  uart_tx_data_out;
    logic        uart_tx_we_out;
    logic        uart_tx_busy_in;
    logic [7:0]  uart_rx_data_in = 8'h00;
    logic        uart_rx_valid_in = 1'b0;
    logic        uart_rx_re_out;
    logic [15:0] led_out;
    logic        irq_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_cnt = 0;
    int ack_cnt = 0;
    int last_wcyc = 0;
    bit hold_busy = 1'b0;
    logic [7:0] launch_data[$];
    int         launch_cyc[$];

    mmio_uart_bridge #(
        .TX_DEPTH(4), .RX_DEPTH(16), .LED_WIDTH(16),
        .UART_BASE(UB), .LED_BASE(LB)
    ) dut (
        .clk(clk), .rst(rst),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
        .bus_rdata(bus_rdata), .bus_hit(bus_hit),
        .uart_tx_data_out(uart_tx_data_out), .uart_tx_we_out(uart_tx_we_out),
        .uart_tx_busy_in(uart_tx_busy_in),
        .uart_rx_data_in(uart_rx_data_in), .uart_rx_valid_in(uart_rx_valid_in),
        .uart_rx_re_out(uart_rx_re_out),
        .led_out(led_out), .irq_out(irq_out)
    );

    always #5 clk = ~clk;

    assign uart_tx_busy_in = hold_busy | (busy_cnt != 0);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) busy_cnt <= 0;
        else if (uart_tx_we_out) busy_cnt <= 10;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
        if (uart_rx_re_out) ack_cnt <= ack_cnt + 1;
    end

    always @(negedge clk) begin
        if (uart_tx_we_out) begin
            launch_data.push_back(uart_tx_data_out);
            launch_cyc.push_back(cyc);
        end
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_addr = a; bus_wdata = d; bus_we = 1'b1; last_wcyc = cyc;
        $display("WR  addr=%08h data=%08h", a, d);
        @(negedge clk);
        bus_we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus_addr = a; bus_re = 1'b1;
        #1 d = bus_rdata;
        $display("RD  addr=%08h data=%08h", a, d);
        @(negedge clk);
        bus_re = 1'b0;
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        bus_addr = a;
        #1 d = bus_rdata;
        $display("PK  addr=%08h data=%08h", a, d);
    endtask

    task automatic send_rx(input logic [7:0] b);
        bit acked = 1'b0;
        @(negedge clk);
        uart_rx_data_in = b; uart_rx_valid_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (uart_rx_re_out) begin acked = 1'b1; break; end
            @(negedge clk);
        end
        uart_rx_valid_in = 1'b0;
        $display("RX  byte=%02h acked=%0d", b, acked);
        checks++;
        if (!acked) begin errors++; $display("FAIL rx_ack_timeout byte=%02h got no ack, expected ack", b); end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        peek(A_STAT, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status got=%08h exp=00000000", d); end
        peek(A_LVL, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_level got=%08h exp=00000000", d); end
        checks++; if (led_out !== 16'h0) begin errors++; $display("FAIL reset_led got=%04h exp=0000", led_out); end
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL reset_irq got=%0b exp=0", irq_out); end
        checks++;
        if (uart_tx_we_out !== 1'b0 || uart_rx_re_out !== 1'b0 || uart_tx_data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_uart_outs got we=%0b re=%0b data=%02h exp 0/0/00",
                     uart_tx_we_out, uart_rx_re_out, uart_tx_data_out);
        end
    endtask

    task automatic test_tx_drain();
        int first_wcyc;
        int idle_cyc = -1;
        logic [7:0] exp_b;
        launch_data.delete(); launch_cyc.delete();
        bus_write(A_DATA, 32'h41);
        first_wcyc = last_wcyc;
        bus_write(A_DATA, 32'h42);
        bus_write(A_DATA, 32'h43);
        bus_addr = A_STAT;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (!bus_rdata[1]) begin idle_cyc = cyc; break; end
        end
        $display("TX  launches=%0d idle_cyc=%0d", launch_data.size(), idle_cyc);
        checks++; if (idle_cyc < 0) begin errors++; $display("FAIL tx_drain_timeout got busy, exp idle within 200 cycles"); end
        checks++; if (launch_data.size() != 3) begin errors++; $display("FAIL tx_launch_count got=%0d exp=3", launch_data.size()); end
        if (launch_data.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                exp_b = 8'h41 + 8'(i);
                checks++;
                if (launch_data[i] !== exp_b) begin errors++; $display("FAIL tx_data[%0d] got=%02h exp=%02h", i, launch_data[i], exp_b); end
            end
            // Pulse lands in the cycle two clocks after the store's cycle
            checks++;
            if (launch_cyc[0] != first_wcyc + 2) begin errors++; $display("FAIL tx_latency got=%0d exp=%0d", launch_cyc[0] - first_wcyc, 2); end
            checks++;
            if (launch_cyc[1] - launch_cyc[0] < 12 || launch_cyc[2] - launch_cyc[1] < 12) begin
                errors++;
                $display("FAIL tx_spacing got=%0d,%0d exp>=12", launch_cyc[1] - launch_cyc[0], launch_cyc[2] - launch_cyc[1]);
            end
            checks++;
            if (idle_cyc <= launch_cyc[2] + 10) begin errors++; $display("FAIL tx_busy_early got idle at %0d exp after %0d", idle_cyc, launch_cyc[2] + 10); end
        end
    endtask

    task automatic test_tx_full();
        logic [31:0] d;
        int idle_cyc = -1;
        logic [7:0] exp_b;
        hold_busy = 1'b1;
        for (int i = 0; i < 5; i++) bus_write(A_DATA, 32'h10 + 32'(i));
        peek(A_LVL, d);
        checks++; if (d !== 32'h0004_0000) begin errors++; $display("FAIL tx_full_level got=%08h exp=00040000", d); end
        peek(A_STAT, d);
        checks++; if (d !== 32'h26) begin errors++; $display("FAIL tx_full_status got=%08h exp=00000026", d); end
        bus_write(A_CTRL, 32'h20);
        peek(A_STAT, d);
        checks++; if (d !== 32'h06) begin errors++; $display("FAIL tx_drop_clear got=%08h exp=00000006", d); end
        peek(A_CTRL, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL ctrl_readback got=%08h exp=00000000", d); end
        launch_data.delete(); launch_cyc.delete();
        @(negedge clk);
        hold_busy = 1'b0;
        bus_addr = A_STAT;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (!bus_rdata[1]) begin idle_cyc = cyc; break; end
        end
        checks++; if (idle_cyc < 0) begin errors++; $display("FAIL tx_full_drain_timeout got busy, exp idle within 300 cycles"); end
        checks++; if (launch_data.size() != 4) begin errors++; $display("FAIL tx_full_launches got=%0d exp=4", launch_data.size()); end
        if (launch_data.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                exp_b = 8'h10 + 8'(i);
                checks++;
                if (launch_data[i] !== exp_b) begin errors++; $display("FAIL tx_full_data[%0d] got=%02h exp=%02h", i, launch_data[i], exp_b); end
            end
        end
    endtask

    task automatic test_rx_overrun();
        logic [31:0] d;
        int ack0 = ack_cnt;
        for (int i = 0; i < 17; i++) send_rx(8'h80 + 8'(i));
        repeat (2) @(negedge clk);
        checks++; if (ack_cnt - ack0 != 17) begin errors++; $display("FAIL rx_acks got=%0d exp=17", ack_cnt - ack0); end
        peek(A_LVL, d);
        checks++; if (d !== 32'h10) begin errors++; $display("FAIL rx_full_level got=%08h exp=00000010", d); end
        peek(A_STAT, d);
        checks++; if (d !== 32'h19) begin errors++; $display("FAIL rx_full_status got=%08h exp=00000019", d); end
        for (int i = 0; i < 16; i++) begin
            bus_read(A_DATA, d);
            checks++;
            if (d !== 32'h80 + 32'(i)) begin errors++; $display("FAIL rx_data[%0d] got=%08h exp=%08h", i, d, 32'h80 + 32'(i)); end
        end
        peek(A_LVL, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rx_empty_level got=%08h exp=00000000", d); end
        bus_read(A_DATA, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rx_empty_read got=%08h exp=00000000", d); end
        peek(A_STAT, d);
        checks++; if (d !== 32'h10) begin errors++; $display("FAIL rx_overrun_sticky got=%08h exp=00000010", d); end
        bus_write(A_CTRL, 32'h10);
        peek(A_STAT, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rx_overrun_clear got=%08h exp=00000000", d); end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        bus_write(A_CTRL, 32'h1);
        #1;
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL irq_idle got=%0b exp=0", irq_out); end
        send_rx(8'h5A);
        repeat (2) @(negedge clk);
        #1;
        checks++; if (irq_out !== 1'b1) begin errors++; $display("FAIL irq_rx got=%0b exp=1", irq_out); end
        bus_read(A_DATA, d);
        checks++; if (d !== 32'h5A) begin errors++; $display("FAIL irq_rx_data got=%08h exp=0000005a", d); end
        #1;
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL irq_rx_clear got=%0b exp=0", irq_out); end
        bus_write(A_CTRL, 32'h2);
        #1;
        checks++; if (irq_out !== 1'b1) begin errors++; $display("FAIL irq_tx_empty got=%0b exp=1", irq_out); end
        bus_write(A_CTRL, 32'h0);
        #1;
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL irq_disabled got=%0b exp=0", irq_out); end
    endtask

    task automatic test_led_decode();
        logic [31:0] d;
        bus_write(LB, 32'h0000_BEEF);
        checks++; if (led_out !== 16'hBEEF) begin errors++; $display("FAIL led_write got=%04h exp=beef", led_out); end
        bus_read(LB, d);
        checks++; if (d !== 32'h0000_BEEF) begin errors++; $display("FAIL led_read got=%08h exp=0000beef", d); end
        @(negedge clk);
        bus_addr = 32'h0000_0100; bus_wdata = 32'h1234; bus_we = 1'b1;
        #1;
        $display("WR  addr=%08h data=%08h hit=%0b", bus_addr, bus_wdata, bus_hit);
        checks++; if (bus_hit !== 1'b0) begin errors++; $display("FAIL unmapped_hit got=%0b exp=0", bus_hit); end
        checks++; if (bus_rdata !== 32'h0) begin errors++; $display("FAIL unmapped_rdata got=%08h exp=00000000", bus_rdata); end
        @(negedge clk);
        bus_we = 1'b0;
        checks++; if (led_out !== 16'hBEEF) begin errors++; $display("FAIL led_untouched got=%04h exp=beef", led_out); end
        peek(UB + 32'h6, d);
        checks++; if (bus_hit !== 1'b1) begin errors++; $display("FAIL byte_offset_hit got=%0b exp=1", bus_hit); end
    endtask

    task automatic test_reset_mid_launch();
        logic [31:0] d;
        bit seen = 1'b0;
        hold_busy = 1'b1;
        for (int i = 0; i < 3; i++) bus_write(A_DATA, 32'h70 + 32'(i));
        @(negedge clk);
        hold_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (uart_tx_we_out) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL rst_launch_timeout got no launch, exp launch"); end
        #1 rst = 1'b1;
        #1;
        $display("RST mid-launch we=%0b", uart_tx_we_out);
        checks++; if (uart_tx_we_out !== 1'b0) begin errors++; $display("FAIL rst_we_drop got=%0b exp=0", uart_tx_we_out); end
        peek(A_LVL, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_level got=%08h exp=00000000", d); end
        checks++; if (led_out !== 16'h0) begin errors++; $display("FAIL rst_led got=%04h exp=0000", led_out); end
        launch_data.delete(); launch_cyc.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (launch_data.size() != 0) begin errors++; $display("FAIL rst_no_relaunch got=%0d exp=0", launch_data.size()); end
    endtask

    initial begin
        test_reset();
        test_tx_drain();
        test_tx_full();
        test_rx_overrun();
        test_irq();
        test_led_decode();
        test_reset_mid_launch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
